// File: rtl/proc_pkg.sv
// Shared processor package.
// Holds the default datapath widths, the register-file write record and the
// write-port arbiter priority encoding used by rf_write_arbiter.
package proc_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    // PRI0: requester 0 wins a tie; PRI1: requester 1 wins a tie.
    typedef enum logic {
        PRI0 = 1'b0,
        PRI1 = 1'b1
    } arb_pri_e;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] data;
    } rf_wr_t;

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Bus interface for rf_write_arbiter.
// Groups both requester handshakes (valid/addr/data/ready), the 2:1 mux select
// and the registered RF write port (wr_en/wr_addr/wr_data/wr_ready).
// Optional build macro RF_ARB_STATS_EN adds the grant/stall statistics outputs.
// Modports:
//   master - the arbiter side (drives ready, mux_sel, wr_*, stats)
//   slave  - the environment side (requesters and RF port)
interface rf_write_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) ();

    logic              req0_valid;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;
    logic              req1_valid;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;
    logic              mux_sel;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
`ifdef RF_ARB_STATS_EN
    logic [15:0]       grant_cnt0;
    logic [15:0]       grant_cnt1;
    logic [15:0]       stall_cnt;
`endif

    modport master (
`ifdef RF_ARB_STATS_EN
        output grant_cnt0, grant_cnt1, stall_cnt,
`endif
        input  req0_valid, req0_addr, req0_data,
        output req0_ready,
        input  req1_valid, req1_addr, req1_data,
        output req1_ready,
        output mux_sel,
        output wr_en, wr_addr, wr_data,
        input  wr_ready
    );

    modport slave (
`ifdef RF_ARB_STATS_EN
        input  grant_cnt0, grant_cnt1, stall_cnt,
`endif
        output req0_valid, req0_addr, req0_data,
        input  req0_ready,
        output req1_valid, req1_addr, req1_data,
        input  req1_ready,
        input  mux_sel,
        input  wr_en, wr_addr, wr_data,
        output wr_ready
    );

endinterface

// File: rtl/mux2to1.sv
// Library 1-bit 2:1 multiplexer cell.
// Ports: a0_i (selected when sel_i=0), a1_i (selected when sel_i=1), sel_i, y_o.
module mux2to1 (
    input  logic a0_i,
    input  logic a1_i,
    input  logic sel_i,
    output logic y_o
);

    assign y_o = sel_i ? a1_i : a0_i;

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter.
// Shares the single RF write port between req0 (ALU result) and req1
// (load/aux result) using round-robin priority and valid/ready handshakes,
// with one registered output stage towards the RF.
// Ports:
//   clk   - clock, rising edge
//   reset - asynchronous, active-high
//   bus   - rf_write_arbiter_if.master: requester handshakes, mux_sel,
//           registered wr_en/wr_addr/wr_data, wr_ready from the RF
// Optional build macro RF_ARB_STATS_EN: adds saturating grant_cnt0/grant_cnt1
// and stall_cnt counters on the interface.
module rf_write_arbiter
    import proc_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    rf_write_arbiter_if.master  bus
);

    localparam int W = ADDR_W + DATA_W;

    arb_pri_e          pri_q, pri_d;
    logic              sel_q, sel_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    logic              load_ok;
    logic              winner;
    logic              xfer0, xfer1;
    logic [W-1:0]      cand0, cand1, mux_y;

    assign cand0 = {bus.req0_addr, bus.req0_data};
    assign cand1 = {bus.req1_addr, bus.req1_data};

    // Address and data are steered together, one mux cell per bit.
    for (genvar i = 0; i < W; i++) begin : g_mux
        mux2to1 u_mux (
            .a0_i  (cand0[i]),
            .a1_i  (cand1[i]),
            .sel_i (winner),
            .y_o   (mux_y[i])
        );
    end

    always_comb begin
        load_ok = !wr_en_q || bus.wr_ready;

        // Ties follow the priority state; with nothing valid the select
        // parks on the last granted requester.
        case ({bus.req1_valid, bus.req0_valid})
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = (pri_q == PRI1);
            default: winner = sel_q;
        endcase

        xfer0 = load_ok && !winner && bus.req0_valid;
        xfer1 = load_ok &&  winner && bus.req1_valid;

        pri_d = pri_q;
        if (xfer0 && pri_q == PRI0) begin
            pri_d = PRI1;
        end else if (xfer1 && pri_q == PRI1) begin
            pri_d = PRI0;
        end

        sel_d = (xfer0 || xfer1) ? winner : sel_q;

        wr_en_d   = wr_en_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (load_ok) begin
            wr_en_d = xfer0 || xfer1;
            if (xfer0 || xfer1) begin
                {wr_addr_d, wr_data_d} = mux_y;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pri_q     <= PRI0;
            sel_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            pri_q     <= pri_d;
            sel_q     <= sel_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign bus.req0_ready = xfer0;
    assign bus.req1_ready = xfer1;
    assign bus.mux_sel    = winner;
    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;

`ifdef RF_ARB_STATS_EN
    logic [15:0] gcnt0_q, gcnt1_q, stall_q;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gcnt0_q <= '0;
            gcnt1_q <= '0;
            stall_q <= '0;
        end else begin
            if (xfer0)                     gcnt0_q <= sat_inc(gcnt0_q);
            if (xfer1)                     gcnt1_q <= sat_inc(gcnt1_q);
            if (wr_en_q && !bus.wr_ready)  stall_q <= sat_inc(stall_q);
        end
    end

    assign bus.grant_cnt0 = gcnt0_q;
    assign bus.grant_cnt1 = gcnt1_q;
    assign bus.stall_cnt  = stall_q;
`endif

endmodule
